// File: rtl/step_move_gen.sv
// Knight/king pseudo-legal move generator: scans a latched board image and
// streams one move record per valid/ready handshake, then pulses done.
module step_move_gen #(
  parameter int SQ_W  = 6,
  parameter int PC_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             side,
  input  logic [255:0]     board,
  output logic             move_valid,
  input  logic             move_ready,
  output logic [SQ_W-1:0]  move_from,
  output logic [SQ_W-1:0]  move_to,
  output logic [PC_W-1:0]  move_piece,
  output logic [PC_W-1:0]  move_capture,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] move_count
);

  typedef enum logic [2:0] {IDLE, SCAN, CHECK, EMIT, FIN} state_t;

  state_t          state, state_next;
  logic [255:0]    board_q;
  logic            side_q;
  logic [SQ_W-1:0] sq;
  logic [2:0]      dir;

  logic [PC_W-1:0] piece, target_pc;
  logic            is_king, own_mover, target_own, on_board, emit_ok;
  logic            last_dir, last_sq;
  logic [3:0]      dr, df, rank_sum, file_sum;
  logic [SQ_W-1:0] target;

  assign piece     = board_q[{sq, 2'b00} +: PC_W];
  assign is_king   = (piece[2:0] == 3'd6);
  assign own_mover = (piece[3] == side_q) && ((piece[2:0] == 3'd3) || is_king);
  assign last_dir  = (dir == 3'd7);
  assign last_sq   = (sq == SQ_W'(63));

  // Rank/file offsets as 4-bit two's complement; the spare top bit flags off-board.
  always_comb begin
    dr = 4'd0;
    df = 4'd0;
    if (is_king) begin
      case (dir)
        3'd0: begin dr = 4'd1;  df = 4'd1;  end
        3'd1: begin dr = 4'd1;  df = 4'd0;  end
        3'd2: begin dr = 4'd1;  df = 4'hF;  end
        3'd3: begin dr = 4'd0;  df = 4'd1;  end
        3'd4: begin dr = 4'd0;  df = 4'hF;  end
        3'd5: begin dr = 4'hF;  df = 4'd1;  end
        3'd6: begin dr = 4'hF;  df = 4'd0;  end
        default: begin dr = 4'hF; df = 4'hF; end
      endcase
    end else begin
      case (dir)
        3'd0: begin dr = 4'd2;  df = 4'd1;  end
        3'd1: begin dr = 4'd2;  df = 4'hF;  end
        3'd2: begin dr = 4'd1;  df = 4'd2;  end
        3'd3: begin dr = 4'd1;  df = 4'hE;  end
        3'd4: begin dr = 4'hF;  df = 4'd2;  end
        3'd5: begin dr = 4'hF;  df = 4'hE;  end
        3'd6: begin dr = 4'hE;  df = 4'd1;  end
        default: begin dr = 4'hE; df = 4'hF; end
      endcase
    end
  end

  // Sums span -2..9, so bit 3 is set exactly when the coordinate leaves 0..7.
  assign rank_sum   = {1'b0, sq[5:3]} + dr;
  assign file_sum   = {1'b0, sq[2:0]} + df;
  assign on_board   = !rank_sum[3] && !file_sum[3];
  assign target     = {rank_sum[2:0], file_sum[2:0]};
  assign target_pc  = board_q[{target, 2'b00} +: PC_W];
  assign target_own = (target_pc != '0) && (target_pc[3] == side_q);
  assign emit_ok    = on_board && !target_own;

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    move_valid = 1'b0;
    case (state)
      IDLE: if (start) state_next = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (own_mover)    state_next = CHECK;
        else if (last_sq) state_next = FIN;
      end
      CHECK: begin
        busy = 1'b1;
        if (emit_ok)       state_next = EMIT;
        else if (last_dir) state_next = last_sq ? FIN : SCAN;
      end
      EMIT: begin
        busy       = 1'b1;
        move_valid = 1'b1;
        if (move_ready) begin
          if (last_dir) state_next = last_sq ? FIN : SCAN;
          else          state_next = CHECK;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // dir wraps 7->0 on its own, so advancing only needs the square bump.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      board_q      <= '0;
      side_q       <= 1'b0;
      sq           <= '0;
      dir          <= '0;
      move_count   <= '0;
      move_from    <= '0;
      move_to      <= '0;
      move_piece   <= '0;
      move_capture <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          board_q    <= board;
          side_q     <= side;
          sq         <= '0;
          dir        <= '0;
          move_count <= '0;
        end
        SCAN: begin
          if (own_mover)     dir <= '0;
          else if (!last_sq) sq  <= sq + SQ_W'(1);
        end
        CHECK: begin
          if (emit_ok) begin
            move_from    <= sq;
            move_to      <= target;
            move_piece   <= piece;
            move_capture <= target_pc;
          end else begin
            dir <= dir + 3'd1;
            if (last_dir && !last_sq) sq <= sq + SQ_W'(1);
          end
        end
        EMIT: if (move_ready) begin
          move_count <= move_count + CNT_W'(1);
          dir        <= dir + 3'd1;
          if (last_dir && !last_sq) sq <= sq + SQ_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/step_move_gen.md
Name: step_move_gen

Overview:
- Downstream consumer of the board state held by the chess control slave (board words at slave addresses 2..9, start command at address 0).
- On start, scans all 64 squares and enumerates pseudo-legal knight and king moves for the side to move.
- Streams one move record per valid/ready handshake to the move-list writer.
- Reports completion and the total move count back to the control block; the control block's lmgdone is driven from done.

Parameters:
- SQ_W, 6, square index width (64 squares)
- PC_W, 4, piece nibble width
- CNT_W, 8, move_count width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin generation; ignored unless idle
- side  in  1  side to move: 0 = white, 1 = black; latched on start
- board  in  256  board image; board[32k+31:32k] = control word at address k+2; square s is nibble board[4s+3:4s]; latched on start
- move_valid  out  1  move record present
- move_ready  in  1  downstream accepts record
- move_from  out  6  source square
- move_to  out  6  destination square
- move_piece  out  4  moving piece nibble
- move_capture  out  4  nibble at destination (0 = quiet move)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- move_count  out  8  moves emitted in last run; held until next start

Behaviour:
- Square and piece encoding:
  - s = rank*8 + file.
  - Piece codes: 0 empty, 1 pawn, 2 rook, 3 knight, 4 bishop, 5 queen, 6 king.
  - Bit 3 = colour (0 white, 1 black).
  - A piece is "own" when its nonzero nibble has bit 3 equal to side; "enemy" when nonzero with bit 3 != side.
- Reset:
  - State goes to IDLE.
  - move_valid, busy, done, move_count, move_from, move_to, move_piece and move_capture all become 0.
  - Reset mid-run aborts immediately; no done pulse is produced.
- FSM states: IDLE, SCAN, CHECK, EMIT, FIN.
- IDLE:
  - When start=1, latch board and side, set sq=0, clear move_count, set busy=1, go to SCAN.
  - start while busy has no effect.
- SCAN (one cycle per square):
  - If the piece at sq is an own knight or own king: dir=0, go to CHECK.
  - Otherwise, if sq=63 go to FIN; else sq+1 and stay in SCAN.
- CHECK (one cycle per direction):
  - Compute the target square from (dr,df).
  - The target is valid only if 0 <= rank+dr <= 7 and 0 <= file+df <= 7. There is no file wrap-around; for example, h-file +1 is invalid.
  - If valid and the target is not own, load the move record and go to EMIT.
  - Otherwise advance dir. After dir 7, if sq=63 go to FIN; else sq+1 and go to SCAN.
- EMIT:
  - move_valid=1, with all record fields held stable until move_ready=1.
  - On handshake: move_count+1, advance dir exactly as in CHECK, and move_valid drops the next cycle.
- Direction order:
  - Knight: (+2,+1) (+2,-1) (+1,+2) (+1,-2) (-1,+2) (-1,-2) (-2,+1) (-2,-1).
  - King: (+1,+1) (+1,0) (+1,-1) (0,+1) (0,-1) (-1,+1) (-1,0) (-1,-1).
- FIN:
  - done=1 for one cycle, busy=0, go to IDLE.
  - move_count is stable when done rises.
- Latency: with no own knight or king on the board, done is high in the 65th cycle after the start edge.
- Width rules:
  - move_count cannot overflow: the maximum is 10 knights × 8 + 8 = 88.
  - Target square arithmetic is done on separate 3-bit rank/file values with a sign check, never on the 6-bit sum.
- Pawns, sliders, castling, check legality: out of scope.

Test Plan:
- Board words 0x23465432 at address 2, others 0; side=0; move_ready=1.
  -> Moves in order: 1→18, 1→16, 1→11, 4→13, 4→12, 4→11, 6→23, 6→21, 6→12.
  -> All with capture=0.
  -> move_count=9, one done pulse.
- Same board, side=1.
  -> No move_valid.
  -> done in the 65th cycle after start, move_count=0.
- White knight (3) on sq0, black pawn (9) on sq17, side=0.
  -> 0→17 with capture=9, then 0→10 with capture=0.
  -> move_count=2.
- White king (6) alone on sq7.
  -> Moves 7→15, 7→14, 7→6 only (no wrap to sq8 or sq0).
  -> move_count=3.
- Backpressure: first test with move_ready held low 5 cycles at each record.
  -> Fields stable while valid is high.
  -> Same 9 moves, no duplicates or drops.
- Reset asserted while in EMIT.
  -> Next cycle all outputs 0, state IDLE, no done pulse.
  -> A following start produces a full correct run.
- start pulsed while busy.
  -> Ignored; the current run completes unchanged.
